// File: rtl/decoder_mul_pkg.sv
// Shared widths and minterm masks for the decoder-style 2x2 unsigned multiplier.
// Bit k of a mask is set when minterm k contributes to that product bit.
package decoder_mul_pkg;

  localparam int IN_W   = 4;
  localparam int DEC_W  = 16;
  localparam int PROD_W = 4;

  localparam logic [DEC_W-1:0] MASK_F0 = 16'hA0A0;
  localparam logic [DEC_W-1:0] MASK_F1 = 16'h6AC0;
  localparam logic [DEC_W-1:0] MASK_F2 = 16'h4C00;
  localparam logic [DEC_W-1:0] MASK_F3 = 16'h8000;

  // Indexed by product bit: PROD_MASKS[k] selects the minterms of f<k>.
  localparam logic [PROD_W-1:0][DEC_W-1:0] PROD_MASKS =
    {MASK_F3, MASK_F2, MASK_F1, MASK_F0};

endpackage

// File: rtl/decoder_mul2x2_if.sv
// Operand/product bundle for decoder_mul2x2; dec_err exists only when
// DECODER_MUL_ONEHOT_CHECK_EN is defined.
interface decoder_mul2x2_if;
  logic a;
  logic b;
  logic c;
  logic d;
  logic f0;
  logic f1;
  logic f2;
  logic f3;
`ifdef DECODER_MUL_ONEHOT_CHECK_EN
  logic dec_err;
`endif

  modport master (
    output a, b, c, d,
    input  f0, f1, f2, f3
`ifdef DECODER_MUL_ONEHOT_CHECK_EN
    , input dec_err
`endif
  );

  modport slave (
    input  a, b, c, d,
    output f0, f1, f2, f3
`ifdef DECODER_MUL_ONEHOT_CHECK_EN
    , output dec_err
`endif
  );
endinterface

// File: rtl/decoder_mul2x2_dec4to16.sv
// Combinational 4-to-16 one-hot decoder: onehot = 1 << sel.
module dec4to16
  import decoder_mul_pkg::*;
(
  input  logic [IN_W-1:0]  sel,
  output logic [DEC_W-1:0] onehot
);

  assign onehot = {{(DEC_W-1){1'b0}}, 1'b1} << sel;

endmodule

// File: rtl/decoder_mul2x2.sv
// Registered 2x2 unsigned multiplier: decode {a,b,c,d} to minterms, OR through masks.
// Optional one-hot sanity flop dec_err under DECODER_MUL_ONEHOT_CHECK_EN.
module decoder_mul2x2
  import decoder_mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  decoder_mul2x2_if.slave bus
);

  logic [IN_W-1:0]   sel;
  logic [DEC_W-1:0]  onehot;
  logic [PROD_W-1:0] prod_d;
  logic [PROD_W-1:0] prod_q;

  assign sel = {bus.a, bus.b, bus.c, bus.d};

  dec4to16 u_dec (
    .sel    (sel),
    .onehot (onehot)
  );

  generate
    for (genvar gi = 0; gi < PROD_W; gi++) begin : g_prod
      assign prod_d[gi] = |(onehot & PROD_MASKS[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign bus.f0 = prod_q[0];
  assign bus.f1 = prod_q[1];
  assign bus.f2 = prod_q[2];
  assign bus.f3 = prod_q[3];

`ifdef DECODER_MUL_ONEHOT_CHECK_EN
  logic dec_err_d;
  logic dec_err_q;

  // x & (x-1) clears the lowest set bit, so it is zero only for 0 or one-hot.
  assign dec_err_d = (onehot == '0) || ((onehot & (onehot - 1'b1)) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_err_q <= 1'b0;
    end else begin
      dec_err_q <= dec_err_d;
    end
  end

  assign bus.dec_err = dec_err_q;
`endif

endmodule

// File: tb/tb_decoder_mul2x2.sv
// Scoreboard bench for decoder_mul2x2: stimulus pushes expected products,
// a monitor pops and checks one cycle later.
module tb_decoder_mul2x2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  // {dec_err, f3..f0}
  logic [4:0] exp_q[$];
  logic [3:0] tab [16];

  decoder_mul2x2_if bus ();

  decoder_mul2x2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] actual();
    logic e;
    e = 1'b0;
`ifdef DECODER_MUL_ONEHOT_CHECK_EN
    e = bus.dec_err;
`endif
    return {e, bus.f3, bus.f2, bus.f1, bus.f0};
  endfunction

  task automatic set_in(input logic [3:0] v);
    {bus.a, bus.b, bus.c, bus.d} = v;
  endtask

  task automatic apply(input logic r, input logic [3:0] v, input logic [3:0] exp_p, input logic exp_e);
    @(negedge clk);
    #1;
    rst = r;
    set_in(v);
    exp_q.push_back({exp_e, exp_p});
  endtask

  // Inputs glitch around the sampling edge but settle on v at the edge itself.
  task automatic glitch(input logic [3:0] v, input logic [3:0] g);
    @(negedge clk);
    #1;
    rst = 1'b0;
    set_in(g);
    #1 set_in(v);
    exp_q.push_back({1'b0, tab[v]});
    #1 set_in(g);
    #1 set_in(v);
    @(posedge clk);
    #2 set_in(g);
  endtask

  task automatic compare(input string name, input logic [4:0] exp_v);
    logic [4:0] act;
    act = actual();
    checks++;
`ifdef DECODER_MUL_ONEHOT_CHECK_EN
    if (act !== exp_v) begin
`else
    if (act[3:0] !== exp_v[3:0]) begin
`endif
      errors++;
      $display("FAIL %s: got err=%b prod=%b, expected err=%b prod=%b",
               name, act[4], act[3:0], exp_v[4], exp_v[3:0]);
    end else begin
      $display("ok   %s: prod=%b err=%b", name, act[3:0], act[4]);
    end
  endtask

  // Monitor: compare just after each edge and again mid-cycle to confirm hold.
  initial begin
    logic [4:0] e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("edge", e);
        #3;
        compare("hold", e);
      end
    end
  end

  initial begin
    tab[0]  = 4'd0; tab[1]  = 4'd0; tab[2]  = 4'd0; tab[3]  = 4'd0;
    tab[4]  = 4'd0; tab[5]  = 4'd1; tab[6]  = 4'd2; tab[7]  = 4'd3;
    tab[8]  = 4'd0; tab[9]  = 4'd2; tab[10] = 4'd4; tab[11] = 4'd6;
    tab[12] = 4'd0; tab[13] = 4'd3; tab[14] = 4'd6; tab[15] = 4'd9;

    rst = 1'b1;
    set_in(4'b1111);

    // Reset holds outputs at zero despite 1111 on the inputs.
    apply(1'b1, 4'b1111, 4'd0, 1'b0);
    apply(1'b1, 4'b1111, 4'd0, 1'b0);
    apply(1'b0, 4'b1111, 4'd9, 1'b0);

    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 4'(i), tab[i], 1'b0);
    end

    // Zero operand on either side.
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, {2'b00, 2'(k)}, 4'd0, 1'b0);
      apply(1'b0, {2'(k), 2'b00}, 4'd0, 1'b0);
    end

    // Mid-stream reset.
    apply(1'b0, 4'b1110, 4'd6, 1'b0);
    apply(1'b1, 4'b0111, 4'd0, 1'b0);
    apply(1'b0, 4'b0111, 4'd3, 1'b0);

    glitch(4'b1011, 4'b1111);
    glitch(4'b0101, 4'b1010);
    glitch(4'b1111, 4'b0000);

`ifdef DECODER_MUL_ONEHOT_CHECK_EN
    // Non-one-hot decoder vectors; products follow the forced minterms.
    @(negedge clk);
    #1;
    set_in(4'b0000);
    force dut.onehot = 16'h0003;
    exp_q.push_back({1'b1, 4'd0});
    @(negedge clk);
    #1;
    force dut.onehot = 16'h0000;
    exp_q.push_back({1'b1, 4'd0});
    @(negedge clk);
    #1;
    release dut.onehot;
    apply(1'b0, 4'b1111, 4'd9, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #6;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish by 100000");
    $fatal(1, "timeout");
  end

endmodule
